// File: rtl/mem_stage_sram_like_pkg.sv
// Shared definitions for the memory-access stage: load/store type bit
// positions, datapath widths and the forwarding bus layout toward decode.
package mem_stage_sram_like_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned LS_TYPE_W       = 6;
    localparam int unsigned MS_TO_DS_BUS_WD = 38;

    localparam int unsigned LS_WORD     = 0;
    localparam int unsigned LS_BYTE     = 1;
    localparam int unsigned LS_HALF     = 2;
    localparam int unsigned LS_LWL      = 3;
    localparam int unsigned LS_LWR      = 4;
    localparam int unsigned LS_UNSIGNED = 5;

    typedef struct packed {
        logic              result_ready;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] result;
    } ms_to_ds_bus_t;

endpackage

// File: rtl/mem_stage_sram_like_load_align.sv
// Combinational load-data extraction: byte/half select with sign or zero
// extension, and LWL/LWR byte merging with the rt operand.
module mem_stage_sram_like_load_align
    import mem_stage_sram_like_pkg::*;
(
    input  logic [LS_TYPE_W-1:0] ls_type,
    input  logic [1:0]           laddr,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [DATA_W-1:0]    rt,
    output logic [DATA_W-1:0]    result_c
);

    logic [4:0]  shamt;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        sext;

    always_comb begin
        shamt    = {laddr, 3'b000};
        byte_val = 8'(rdata >> shamt);
        half_val = laddr[1] ? rdata[31:16] : rdata[15:0];
        sext     = !ls_type[LS_UNSIGNED];
        result_c = '0;
        if (ls_type[LS_LWR]) begin
            // low (4-n) bytes come from the high end of the word
            case (laddr)
                2'd0:    result_c = rdata;
                2'd1:    result_c = {rt[31:24], rdata[31:8]};
                2'd2:    result_c = {rt[31:16], rdata[31:16]};
                default: result_c = {rt[31:8],  rdata[31:24]};
            endcase
        end else if (ls_type[LS_LWL]) begin
            // top (n+1) bytes come from the low end of the word
            case (laddr)
                2'd0:    result_c = {rdata[7:0],  rt[23:0]};
                2'd1:    result_c = {rdata[15:0], rt[15:0]};
                2'd2:    result_c = {rdata[23:0], rt[7:0]};
                default: result_c = rdata;
            endcase
        end else if (ls_type[LS_HALF]) begin
            result_c = {{16{sext & half_val[15]}}, half_val};
        end else if (ls_type[LS_BYTE]) begin
            result_c = {{24{sext & byte_val[7]}}, byte_val};
        end else if (ls_type[LS_WORD]) begin
            result_c = rdata;
        end
    end

endmodule

// File: rtl/mem_stage_sram_like.sv
// MEM pipeline stage on a request/data_ok data bus: tracks in-flight
// requests, buffers a response while WB stalls, drops stale responses after
// a flush, aligns load data and drives the decode forwarding bus.
module mem_stage_sram_like
    import mem_stage_sram_like_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic                       es_req_fire,
    input  logic [LS_TYPE_W-1:0]       es_ls_type,
    input  logic [1:0]                 es_ls_laddr,
    input  logic                       es_mem_req,
    input  logic                       es_mem_re,
    input  logic [DATA_W-1:0]          es_rt_value,
    input  logic [DATA_W-1:0]          es_alu_result,
    input  logic                       es_privil,
    input  logic                       es_gpr_we,
    input  logic [REG_W-1:0]           es_dest,
    input  logic [PAYLOAD_W-1:0]       es_payload,
    input  logic                       exc_flush,
    input  logic                       data_sram_data_ok,
    input  logic [DATA_W-1:0]          data_sram_rdata,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    output logic                       ms_can_issue,
    output logic                       ms_to_ws_valid,
    output logic [DATA_W-1:0]          ms_final_result,
    output logic                       ms_gpr_we,
    output logic [REG_W-1:0]           ms_dest,
    output logic [PAYLOAD_W-1:0]       ms_payload,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic                 ms_valid;
    logic [LS_TYPE_W-1:0] ms_ls_type;
    logic [1:0]           ms_laddr;
    logic                 ms_mem_req;
    logic                 ms_mem_re;
    logic [DATA_W-1:0]    ms_rt;
    logic [DATA_W-1:0]    ms_alu;
    logic                 ms_privil;

    logic [CNT_W-1:0]     outst_cnt;
    logic [CNT_W-1:0]     discard_cnt;
    logic                 buf_valid;
    logic [DATA_W-1:0]    rdata_buf;

    logic                 data_ok_live;
    logic                 wait_resp;
    logic                 resp_for_ms;
    logic                 ms_ready_go;
    logic                 leave;
    logic [CNT_W:0]       flush_discard;
    logic [DATA_W-1:0]    load_src;
    logic [DATA_W-1:0]    load_data_c;
    ms_to_ds_bus_t        ds_bus;

    // Handshake and response ownership
    always_comb begin
        data_ok_live   = data_sram_data_ok & (discard_cnt == '0);
        wait_resp      = ms_valid & ms_mem_req & !buf_valid;
        resp_for_ms    = wait_resp & data_ok_live;
        ms_ready_go    = !wait_resp | data_ok_live | buf_valid;
        ms_to_ws_valid = ms_valid & ms_ready_go;
        ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin) | exc_flush;
        leave          = ms_to_ws_valid & ws_allowin;
        ms_can_issue   = outst_cnt < CNT_W'(MAX_OUTST);
        flush_discard  = {1'b0, outst_cnt} + (CNT_W+1)'(es_req_fire)
                         - (CNT_W+1)'(data_ok_live);
        load_src       = buf_valid ? rdata_buf : data_sram_rdata;
    end

    mem_stage_sram_like_load_align u_load_align (
        .ls_type  (ms_ls_type),
        .laddr    (ms_laddr),
        .rdata    (load_src),
        .rt       (ms_rt),
        .result_c (load_data_c)
    );

    always_comb begin
        ms_final_result     = ms_privil ? ms_rt : (ms_mem_re ? load_data_c : ms_alu);
        ds_bus.result_ready = !(ms_mem_re & !ms_ready_go);
        ds_bus.dest         = ms_dest;
        ds_bus.result       = ms_final_result;
        ms_to_ds_bus        = (ms_valid & ms_gpr_we) ? ds_bus : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            ms_ls_type  <= '0;
            ms_laddr    <= '0;
            ms_mem_req  <= 1'b0;
            ms_mem_re   <= 1'b0;
            ms_rt       <= '0;
            ms_alu      <= '0;
            ms_privil   <= 1'b0;
            ms_gpr_we   <= 1'b0;
            ms_dest     <= '0;
            ms_payload  <= '0;
            outst_cnt   <= '0;
            discard_cnt <= '0;
            buf_valid   <= 1'b0;
            rdata_buf   <= '0;
        end else begin
            if (exc_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end

            if (es_to_ms_valid && ms_allowin) begin
                ms_ls_type <= es_ls_type;
                ms_laddr   <= es_ls_laddr;
                ms_mem_req <= es_mem_req;
                ms_mem_re  <= es_mem_re;
                ms_rt      <= es_rt_value;
                ms_alu     <= es_alu_result;
                ms_privil  <= es_privil;
                ms_gpr_we  <= es_gpr_we;
                ms_dest    <= es_dest;
                ms_payload <= es_payload;
            end

            // Everything in flight at a flush becomes stale and is drained silently
            if (exc_flush) begin
                outst_cnt   <= '0;
                discard_cnt <= CNT_W'(flush_discard);
            end else begin
                if (es_req_fire && !data_ok_live) begin
                    outst_cnt <= outst_cnt + CNT_W'(1);
                end else if (!es_req_fire && data_ok_live) begin
                    outst_cnt <= outst_cnt - CNT_W'(1);
                end
                if (data_sram_data_ok && discard_cnt != '0) begin
                    discard_cnt <= discard_cnt - CNT_W'(1);
                end
            end

            if (exc_flush || leave) begin
                buf_valid <= 1'b0;
            end else if (resp_for_ms && !ws_allowin) begin
                buf_valid <= 1'b1;
                rdata_buf <= data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_like.sv
// Self-checking bench for mem_stage_sram_like: table of single load/ALU
// vectors plus hand sequences for WB stall, outstanding limit and flush.
module tb_mem_stage_sram_like;
    import mem_stage_sram_like_pkg::*;

    localparam int unsigned PW = 96;

    logic                       clk;
    logic                       reset;
    logic                       es_to_ms_valid;
    logic                       es_req_fire;
    logic [LS_TYPE_W-1:0]       es_ls_type;
    logic [1:0]                 es_ls_laddr;
    logic                       es_mem_req;
    logic                       es_mem_re;
    logic [31:0]                es_rt_value;
    logic [31:0]                es_alu_result;
    logic                       es_privil;
    logic                       es_gpr_we;
    logic [4:0]                 es_dest;
    logic [PW-1:0]              es_payload;
    logic                       exc_flush;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       ms_can_issue;
    logic                       ms_to_ws_valid;
    logic [31:0]                ms_final_result;
    logic                       ms_gpr_we;
    logic [4:0]                 ms_dest;
    logic [PW-1:0]              ms_payload;
    logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;

    mem_stage_sram_like #(.PAYLOAD_W(PW), .MAX_OUTST(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_req_fire       (es_req_fire),
        .es_ls_type        (es_ls_type),
        .es_ls_laddr       (es_ls_laddr),
        .es_mem_req        (es_mem_req),
        .es_mem_re         (es_mem_re),
        .es_rt_value       (es_rt_value),
        .es_alu_result     (es_alu_result),
        .es_privil         (es_privil),
        .es_gpr_we         (es_gpr_we),
        .es_dest           (es_dest),
        .es_payload        (es_payload),
        .exc_flush         (exc_flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .ms_can_issue      (ms_can_issue),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_final_result   (ms_final_result),
        .ms_gpr_we         (ms_gpr_we),
        .ms_dest           (ms_dest),
        .ms_payload        (ms_payload),
        .ms_to_ds_bus      (ms_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ls_type;
        logic [1:0]  laddr;
        logic        mem_re;
        logic        privil;
        logic        gpr_we;
        logic [4:0]  dest;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 12;
    vec_t        vecs[NVEC];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_req_fire       = 1'b0;
        es_ls_type        = '0;
        es_ls_laddr       = '0;
        es_mem_req        = 1'b0;
        es_mem_re         = 1'b0;
        es_rt_value       = '0;
        es_alu_result     = '0;
        es_privil         = 1'b0;
        es_gpr_we         = 1'b0;
        es_dest           = '0;
        es_payload        = '0;
        exc_flush         = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
    endtask

    task automatic issue_lw(input logic [4:0] dest, input logic [31:0] exp);
        es_to_ms_valid = 1'b1;
        es_req_fire    = 1'b1;
        es_mem_req     = 1'b1;
        es_mem_re      = 1'b1;
        es_ls_type     = 6'b000001;
        es_ls_laddr    = 2'd0;
        es_privil      = 1'b0;
        es_gpr_we      = 1'b1;
        es_dest        = dest;
        exp_q.push_back(exp);
    endtask

    // Scoreboard: every instruction handed to WB must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got result %0h with no expected entry", ms_final_result);
            end else begin
                chk("sb_result", 96'(ms_final_result), 96'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [37:0] exp_bus;
        logic [95:0] exp_pl;

        //           type       laddr re priv we dest  rt            rdata         alu           exp
        vecs[0]  = '{6'b000010, 2'd3, 1, 0, 1, 5'd1, 32'h0,        32'h80FF1234, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{6'b100010, 2'd3, 1, 0, 1, 5'd2, 32'h0,        32'h80FF1234, 32'h0,        32'h00000080};
        vecs[2]  = '{6'b001000, 2'd1, 1, 0, 1, 5'd3, 32'hAABBCCDD, 32'h11223344, 32'h0,        32'h3344CCDD};
        vecs[3]  = '{6'b010000, 2'd1, 1, 0, 1, 5'd4, 32'hAABBCCDD, 32'h11223344, 32'h0,        32'hAA112233};
        vecs[4]  = '{6'b000100, 2'd2, 1, 0, 1, 5'd5, 32'h0,        32'h80017FFF, 32'h0,        32'hFFFF8001};
        vecs[5]  = '{6'b100100, 2'd0, 1, 0, 1, 5'd6, 32'h0,        32'h1234F00D, 32'h0,        32'h0000F00D};
        vecs[6]  = '{6'b000001, 2'd0, 1, 0, 1, 5'd7, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[7]  = '{6'b000010, 2'd1, 1, 0, 1, 5'd8, 32'h0,        32'h80FF1234, 32'h0,        32'h00000012};
        vecs[8]  = '{6'b000000, 2'd0, 0, 0, 1, 5'd9, 32'h0,        32'h0,        32'h00001234, 32'h00001234};
        vecs[9]  = '{6'b000000, 2'd0, 0, 1, 0, 5'd0, 32'hCAFEF00D, 32'h0,        32'h77777777, 32'hCAFEF00D};
        vecs[10] = '{6'b010000, 2'd3, 1, 0, 1, 5'd10, 32'hAABBCCDD, 32'h11223344, 32'h0,       32'hAABBCC11};
        vecs[11] = '{6'b001000, 2'd0, 1, 0, 1, 5'd11, 32'hAABBCCDD, 32'h11223344, 32'h0,       32'h44BBCCDD};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sample();
        chk("rst_allowin",   96'(ms_allowin), 96'(1));
        chk("rst_can_issue", 96'(ms_can_issue), 96'(1));
        chk("rst_to_ws",     96'(ms_to_ws_valid), 96'(0));
        chk("rst_result",    96'(ms_final_result), 96'(0));
        chk("rst_ds_bus",    96'(ms_to_ds_bus), 96'(0));
        chk("rst_gpr_we",    96'(ms_gpr_we), 96'(0));
        chk("rst_dest",      96'(ms_dest), 96'(0));
        chk("rst_payload",   ms_payload, 96'(0));

        // Table vectors: issue in EX, response (if any) in the first MS cycle
        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            es_to_ms_valid = 1'b1;
            es_req_fire    = vecs[i].mem_re;
            es_mem_req     = vecs[i].mem_re;
            es_mem_re      = vecs[i].mem_re;
            es_ls_type     = vecs[i].ls_type;
            es_ls_laddr    = vecs[i].laddr;
            es_rt_value    = vecs[i].rt;
            es_alu_result  = vecs[i].alu;
            es_privil      = vecs[i].privil;
            es_gpr_we      = vecs[i].gpr_we;
            es_dest        = vecs[i].dest;
            exp_pl         = {64'h0123456789ABCDEF, 32'(i)};
            es_payload     = exp_pl;
            exp_q.push_back(vecs[i].exp);
            next_cycle();
            es_to_ms_valid    = 1'b0;
            es_req_fire       = 1'b0;
            data_sram_data_ok = vecs[i].mem_re;
            data_sram_rdata   = vecs[i].rdata;
            sample();
            exp_bus = vecs[i].gpr_we ? {1'b1, vecs[i].dest, vecs[i].exp} : 38'h0;
            chk($sformatf("vec%0d_to_ws", i),   96'(ms_to_ws_valid), 96'(1));
            chk($sformatf("vec%0d_ds_bus", i),  96'(ms_to_ds_bus), 96'(exp_bus));
            chk($sformatf("vec%0d_payload", i), ms_payload, exp_pl);
            next_cycle();
            data_sram_data_ok = 1'b0;
        end

        // LW whose response arrives while WB stalls: buffered and held
        issue_lw(5'd12, 32'h13572468);
        next_cycle();
        es_to_ms_valid = 1'b0;
        es_req_fire    = 1'b0;
        ws_allowin     = 1'b0;
        sample();
        chk("stall_wait_to_ws",  96'(ms_to_ws_valid), 96'(0));
        chk("stall_wait_ready",  96'(ms_to_ds_bus[37]), 96'(0));
        chk("stall_wait_allowin", 96'(ms_allowin), 96'(0));
        next_cycle();
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h13572468;
        sample();
        chk("stall_ok_to_ws", 96'(ms_to_ws_valid), 96'(1));
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'hFFFFFFFF;
            sample();
            chk("stall_hold_to_ws",  96'(ms_to_ws_valid), 96'(1));
            chk("stall_hold_result", 96'(ms_final_result), 96'(32'h13572468));
            chk("stall_hold_allowin", 96'(ms_allowin), 96'(0));
        end
        next_cycle();
        ws_allowin = 1'b1;
        sample();
        chk("stall_release_allowin", 96'(ms_allowin), 96'(1));
        next_cycle();
        sample();
        chk("stall_after_to_ws", 96'(ms_to_ws_valid), 96'(0));
        chk("stall_after_can",   96'(ms_can_issue), 96'(1));

        // Outstanding-request limit
        next_cycle();
        es_req_fire = 1'b1;
        sample();
        chk("outst0_can", 96'(ms_can_issue), 96'(1));
        next_cycle();
        sample();
        chk("outst1_can", 96'(ms_can_issue), 96'(1));
        next_cycle();
        es_req_fire       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0;
        sample();
        chk("outst2_can", 96'(ms_can_issue), 96'(0));
        next_cycle();
        data_sram_data_ok = 1'b0;
        sample();
        chk("outst_dec_can", 96'(ms_can_issue), 96'(1));
        next_cycle();
        es_req_fire       = 1'b1;
        data_sram_data_ok = 1'b1;
        next_cycle();
        es_req_fire       = 1'b0;
        data_sram_data_ok = 1'b0;
        sample();
        chk("outst_same_can", 96'(ms_can_issue), 96'(1));
        next_cycle();
        es_req_fire = 1'b1;
        next_cycle();
        es_req_fire = 1'b0;
        sample();
        chk("outst_same_full", 96'(ms_can_issue), 96'(0));

        // Flush with two requests in flight: both responses must be dropped
        next_cycle();
        exc_flush = 1'b1;
        next_cycle();
        exc_flush = 1'b0;
        sample();
        chk("flush_can", 96'(ms_can_issue), 96'(1));
        next_cycle();
        issue_lw(5'd13, 32'h0BADCAFE);
        next_cycle();
        es_to_ms_valid    = 1'b0;
        es_req_fire       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11111111;
        sample();
        chk("discard1_to_ws", 96'(ms_to_ws_valid), 96'(0));
        next_cycle();
        data_sram_rdata = 32'h22222222;
        sample();
        chk("discard2_to_ws", 96'(ms_to_ws_valid), 96'(0));
        next_cycle();
        data_sram_rdata = 32'h0BADCAFE;
        sample();
        chk("post_flush_to_ws", 96'(ms_to_ws_valid), 96'(1));
        next_cycle();
        data_sram_data_ok = 1'b0;
        sample();
        chk("post_flush_idle", 96'(ms_to_ws_valid), 96'(0));
        chk("post_flush_can",  96'(ms_can_issue), 96'(1));

        // ALU op passes while an unrelated request is still in flight
        next_cycle();
        es_req_fire = 1'b1;
        next_cycle();
        es_req_fire    = 1'b0;
        es_to_ms_valid = 1'b1;
        es_mem_req     = 1'b0;
        es_mem_re      = 1'b0;
        es_ls_type     = '0;
        es_privil      = 1'b0;
        es_gpr_we      = 1'b1;
        es_dest        = 5'd7;
        es_alu_result  = 32'h55AA00FF;
        exp_q.push_back(32'h55AA00FF);
        next_cycle();
        es_to_ms_valid = 1'b0;
        sample();
        chk("addu_to_ws",  96'(ms_to_ws_valid), 96'(1));
        chk("addu_ready",  96'(ms_to_ds_bus[37]), 96'(1));
        chk("addu_ds_bus", 96'(ms_to_ds_bus), 96'({1'b1, 5'd7, 32'h55AA00FF}));
        next_cycle();
        data_sram_data_ok = 1'b1;
        next_cycle();
        data_sram_data_ok = 1'b0;
        sample();
        chk("drain_can", 96'(ms_can_issue), 96'(1));

        chk("sb_drain", 96'(exp_q.size()), 96'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_like.md
# mem_stage_sram_like

Memory-access pipeline stage for the 5-stage MIPS core on a request/`data_ok` SRAM-like data bus, where load/store responses return after a variable latency. It sits between the execute and write-back stages. It tracks up to `MAX_OUTST` in-flight data requests and buffers a response that arrives while write-back stalls. After an exception flush it silently discards stale responses. It aligns and extends LB/LBU/LH/LHU/LW/LWL/LWR load data, and exposes a forwarding bus to decode.

## Interface
- `PAYLOAD_W`, 96: width of opaque sideband (pc, dest, exception flags, CP0 fields) carried EX→WB unchanged
- `MAX_OUTST`, 2: maximum data requests issued but not yet answered (≥1)
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `es_to_ms_valid` in 1: EX holds a valid instruction
- `es_req_fire` in 1: EX's data request handshake completes this cycle (req & addr_ok)
- `es_ls_type` in 6: [5] unsigned, [4] LWR, [3] LWL, [2] half, [1] byte, [0] word
- `es_ls_laddr` in 2: address bits [1:0]
- `es_mem_req` in 1: instruction issued a data request (load or store)
- `es_mem_re` in 1: instruction is a load
- `es_rt_value` in 32: rt operand (LWL/LWR merge, MTC0 result)
- `es_alu_result` in 32: non-load result
- `es_privil` in 1: MTC0; result = rt_value
- `es_gpr_we`, `es_dest` in 1/5: register write enable / destination
- `es_payload` in PAYLOAD_W: sideband
- `exc_flush` in 1: exception/ERET flush from WB
- `data_sram_data_ok` in 1: one response this cycle
- `data_sram_rdata` in 32: response data
- `ws_allowin` in 1: WB can accept
- `ms_allowin` out 1: MS can accept
- `ms_can_issue` out 1: EX may issue a new data request
- `ms_to_ws_valid` out 1; `ms_final_result` out 32; `ms_gpr_we` out 1; `ms_dest` out 5; `ms_payload` out PAYLOAD_W
- `ms_to_ds_bus` out 38: {result_ready, dest, result}, all-zero unless valid & gpr_we

## Operation
- Instruction registers on `es_to_ms_valid & ms_allowin`. `ms_valid` loads `es_to_ms_valid` whenever `ms_allowin`. On `exc_flush`, `ms_valid`←0.
- `outst_cnt` (width clog2(MAX_OUTST+1)): +1 on `es_req_fire`, −1 on `data_ok` when `discard_cnt`==0. Inc and dec in the same cycle leave it unchanged. `ms_can_issue = outst_cnt < MAX_OUTST` (combinational, before the update).
- `discard_cnt`: on `exc_flush`, loads `outst_cnt + es_req_fire − (data_ok & discard_cnt==0)`. While nonzero, each `data_ok` decrements it and the data is dropped (no buffer write, no outst change).
- Wait condition: `ms_valid & mem_req & !buf_valid`. Only the oldest response belongs to MS, so a non-discarded `data_ok` while waiting is MS's data.
- `ms_ready_go = !wait | (data_ok & discard_cnt==0) | buf_valid`.
- `ms_allowin = !ms_valid | (ready_go & ws_allowin) | exc_flush`.
- `rdata_buf`/`buf_valid`: set when MS's `data_ok` arrives and `!ws_allowin`. Cleared when the instruction leaves (`ms_to_ws_valid & ws_allowin`) or on flush.
- Load data source: `buf_valid ? rdata_buf : data_sram_rdata`.
- Extension: LB/LBU pick the byte at laddr; LH/LHU pick the half by laddr[1]; sign-extend unless [5].
- LWL: laddr n → top (n+1) bytes from rdata low bytes, rest from rt.
- LWR: laddr n → low (4−n) bytes from rdata high bytes, rest from rt.
- `final_result = privil ? rt : mem_re ? load_data : alu_result`. `result_ready = !(mem_re & !ready_go)`.

## Timing
- Reset: ms_valid, buf_valid = 0; outst_cnt, discard_cnt = 0; ms_allowin 1; ms_can_issue 1; all other outputs 0.
- Zero extra latency: a `data_ok` in the first valid cycle passes to WB that cycle. Non-memory instructions occupy 1 cycle.
- Flush and `data_ok` in the same cycle: the response is discarded.
- Reset mid-transaction: all counters are cleared. The bus is required to be reset simultaneously.

## Structure
- Shared `mycpu.h`: LS_TYPE bit indices, `MS_TO_DS_BUS_WD`=38.
- Sub-module `load_align`: combinational extraction and extension from (ls_type, laddr, rdata, rt).

## Test plan
- LB laddr=3, rdata 0x80FF1234, data_ok same cycle → result 0xFFFFFF80; LBU → 0x00000080; 1-cycle pass.
- LWL laddr=1, rt 0xAABBCCDD, rdata 0x11223344 → 0x3344CCDD. LWR laddr=1 → 0xAA112233.
- LW, data_ok at cycle 3 with ws_allowin=0 until cycle 6 → buf_valid 3..6; result equals the rdata from cycle 3; ms_to_ws_valid held.
- Two fires, no data_ok → ms_can_issue=0. One data_ok → 1. Fire and data_ok in the same cycle → count unchanged.
- outst_cnt=2, then exc_flush → discard_cnt=2. The next two data_ok are dropped, ms_to_ws_valid stays 0. A new LW afterwards receives the third response.
- Non-load ADDU with a load in flight ahead of it: result_ready=1 for ADDU; for a load while waiting, ms_to_ds_bus[37]=0.
